// File: rtl/udp_tx_arb_pkg.sv
// udp_tx_arb_pkg: shared types and constants for the UDP transmit arbiter.
//   arb_state_e : arbiter FSM states
//   src_t       : one-bit source index (SRC_IMG = image packetizer, SRC_CMD = command replies)
//   sat_inc16   : 16-bit saturating increment used by the cycle counter
package udp_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    GAP
  } arb_state_e;

  typedef logic src_t;

  localparam src_t SRC_IMG = 1'b0;
  localparam src_t SRC_CMD = 1'b1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/udp_tx_arb_pick.sv
// udp_tx_arb_pick: combinational winner select for the UDP transmit arbiter.
// Ports:
//   pend0_i, pend1_i : latched request flags of source 0 / source 1
//   last_i           : source granted most recently (round-robin pointer)
//   valid_o          : at least one request pending
//   win_o            : index of the winning source (meaningful when valid_o)
// Parameter SRC0_STRICT: non-zero gives source 0 strict priority, zero = round-robin.
module udp_tx_arb_pick
  import udp_tx_arb_pkg::*;
#(
  parameter int unsigned SRC0_STRICT = 0
) (
  input  logic pend0_i,
  input  logic pend1_i,
  input  logic last_i,
  output logic valid_o,
  output logic win_o
);

  always_comb begin
    valid_o = pend0_i | pend1_i;
    win_o   = SRC_IMG;
    if (pend0_i && pend1_i) begin
      if (SRC0_STRICT != 0) begin
        win_o = SRC_IMG;
      end else begin
        // tie: the source that was not served last goes next
        win_o = (last_i == SRC_IMG) ? SRC_CMD : SRC_IMG;
      end
    end else if (pend1_i) begin
      win_o = SRC_CMD;
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: shares one UDP transmit channel between two packet sources
// (source 0 = image packetizer, source 1 = command/status replies), all in
// the eth_tx_clk domain. Requests are latched, one source is granted at a
// time, the UDP handshake is forwarded to it, a minimum inter-packet gap is
// enforced and a missing tx_done is recovered by a timeout.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   sN_start_en / sN_byte_num : send request pulse and its byte count
//   sN_data                   : payload word of source N
//   sN_req / sN_done          : udp_tx_req / udp_tx_done forwarded while granted
//   sN_busy                   : request pending or packet in progress for source N
//   udp_tx_start_en/byte_num/data : towards the UDP module
//   udp_tx_req / udp_tx_done  : from the UDP module
//   arb_timeout               : one-cycle pulse when a packet is aborted
// Parameters: GAP_CYCLES, TIMEOUT_CYCLES (0 = no timeout), SRC0_STRICT.
// Optional macro UDP_TX_ARB_STATS_EN adds s0_pkt_cnt, s1_pkt_cnt, drop_cnt
// and timeout_cnt outputs.
module udp_tx_arbiter
  import udp_tx_arb_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned SRC0_STRICT    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s0_start_en,
  input  logic [15:0] s0_byte_num,
  input  logic [31:0] s0_data,
  output logic        s0_req,
  output logic        s0_done,
  output logic        s0_busy,
  input  logic        s1_start_en,
  input  logic [15:0] s1_byte_num,
  input  logic [31:0] s1_data,
  output logic        s1_req,
  output logic        s1_done,
  output logic        s1_busy,
  output logic        udp_tx_start_en,
  output logic [15:0] udp_tx_byte_num,
  output logic [31:0] udp_tx_data,
  input  logic        udp_tx_req,
  input  logic        udp_tx_done,
  output logic        arb_timeout
`ifdef UDP_TX_ARB_STATS_EN
  ,
  output logic [31:0] s0_pkt_cnt,
  output logic [31:0] s1_pkt_cnt,
  output logic [15:0] drop_cnt,
  output logic [15:0] timeout_cnt
`endif
);

  arb_state_e  state_q, state_d;
  logic        pend0_q, pend0_d;
  logic        pend1_q, pend1_d;
  logic [15:0] cap0_q, cap0_d;
  logic [15:0] cap1_q, cap1_d;
  // grant_q doubles as the round-robin pointer: it keeps the last winner
  src_t        grant_q, grant_d;
  logic [15:0] byte_num_q, byte_num_d;
  logic [15:0] cnt_q, cnt_d;

  logic        pick_valid;
  logic        pick_win;
  logic        in_pkt;
  logic        acc0, acc1;
  logic        gap_done, tmo_hit;

  udp_tx_arb_pick #(
    .SRC0_STRICT(SRC0_STRICT)
  ) u_pick (
    .pend0_i(pend0_q),
    .pend1_i(pend1_q),
    .last_i (grant_q),
    .valid_o(pick_valid),
    .win_o  (pick_win)
  );

  // A source is only locked out while its own packet is being started or sent;
  // a re-request during its GAP is latched like any other request.
  assign in_pkt = (state_q == START) || (state_q == BUSY);
  assign acc0   = s0_start_en && (s0_byte_num != 16'd0) && !pend0_q
                  && !(in_pkt && (grant_q == SRC_IMG));
  assign acc1   = s1_start_en && (s1_byte_num != 16'd0) && !pend1_q
                  && !(in_pkt && (grant_q == SRC_CMD));

  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && ({16'd0, cnt_q} >= TIMEOUT_CYCLES);
  assign gap_done = ({16'd0, cnt_q} + 32'd1) >= GAP_CYCLES;

  assign s0_busy = pend0_q | ((grant_q == SRC_IMG) && (state_q != IDLE));
  assign s1_busy = pend1_q | ((grant_q == SRC_CMD) && (state_q != IDLE));
  assign udp_tx_byte_num = byte_num_q;

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    byte_num_d      = byte_num_q;
    pend0_d         = pend0_q;
    pend1_d         = pend1_q;
    cap0_d          = cap0_q;
    cap1_d          = cap1_q;
    udp_tx_start_en = 1'b0;
    udp_tx_data     = '0;
    s0_req          = 1'b0;
    s1_req          = 1'b0;
    s0_done         = 1'b0;
    s1_done         = 1'b0;
    arb_timeout     = 1'b0;

    // an accepted request can never coincide with clearing the same flag,
    // since acceptance requires the flag to be clear
    if (acc0) begin
      pend0_d = 1'b1;
      cap0_d  = s0_byte_num;
    end
    if (acc1) begin
      pend1_d = 1'b1;
      cap1_d  = s1_byte_num;
    end

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = START;
          grant_d = pick_win;
          if (pick_win == SRC_IMG) begin
            pend0_d    = 1'b0;
            byte_num_d = cap0_q;
          end else begin
            pend1_d    = 1'b0;
            byte_num_d = cap1_q;
          end
        end
      end
      START: begin
        udp_tx_start_en = 1'b1;
        state_d         = BUSY;
      end
      BUSY: begin
        udp_tx_data = (grant_q == SRC_IMG) ? s0_data : s1_data;
        s0_req      = (grant_q == SRC_IMG) && udp_tx_req;
        s1_req      = (grant_q == SRC_CMD) && udp_tx_req;
        if (udp_tx_done) begin
          s0_done = (grant_q == SRC_IMG);
          s1_done = (grant_q == SRC_CMD);
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else if (tmo_hit) begin
          arb_timeout = 1'b1;
          state_d     = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // START->BUSY keeps counting so the timeout is measured from the start pulse
    if ((state_d != state_q) && (state_d != BUSY)) begin
      cnt_d = '0;
    end else begin
      cnt_d = sat_inc16(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= SRC_CMD;
      byte_num_q <= '0;
      pend0_q    <= 1'b0;
      pend1_q    <= 1'b0;
      cap0_q     <= '0;
      cap1_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      byte_num_q <= byte_num_d;
      pend0_q    <= pend0_d;
      pend1_q    <= pend1_d;
      cap0_q     <= cap0_d;
      cap1_q     <= cap1_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef UDP_TX_ARB_STATS_EN
  logic        drop0, drop1;
  logic [31:0] s0_pkt_cnt_q, s1_pkt_cnt_q;
  logic [15:0] drop_cnt_q, timeout_cnt_q;

  assign drop0 = s0_start_en && !acc0;
  assign drop1 = s1_start_en && !acc1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_pkt_cnt_q  <= '0;
      s1_pkt_cnt_q  <= '0;
      drop_cnt_q    <= '0;
      timeout_cnt_q <= '0;
    end else begin
      if (s0_done) s0_pkt_cnt_q <= s0_pkt_cnt_q + 32'd1;
      if (s1_done) s1_pkt_cnt_q <= s1_pkt_cnt_q + 32'd1;
      drop_cnt_q <= drop_cnt_q + {15'd0, drop0} + {15'd0, drop1};
      if (arb_timeout) timeout_cnt_q <= timeout_cnt_q + 16'd1;
    end
  end

  assign s0_pkt_cnt  = s0_pkt_cnt_q;
  assign s1_pkt_cnt  = s1_pkt_cnt_q;
  assign drop_cnt    = drop_cnt_q;
  assign timeout_cnt = timeout_cnt_q;
`endif

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares the single UDP transmit channel (tx_start_en / tx_data / tx_byte_num / tx_req / tx_done) between two packet sources in the eth_tx_clk domain.
- Source 0 is the image packetizer. Source 1 is a command/status reply generator.
- Latches each source's send request, grants the channel to one source at a time and forwards the UDP handshake to that source.
- Enforces a minimum inter-packet gap and recovers from a missing tx_done.

Parameters:
- GAP_CYCLES, 16, idle clk cycles inserted after each tx_done (or timeout) before the next grant; 0 allowed.
- TIMEOUT_CYCLES, 65535, max clk cycles from tx_start_en to tx_done before abort; 0 disables the timeout.
- SRC0_STRICT, 0, 1 = source 0 has strict priority; 0 = round-robin.

Ports:
- clk  in  1  eth_tx_clk domain clock
- rst  in  1  synchronous, active-high reset
- s0_start_en  in  1  source 0 send request pulse
- s0_byte_num  in  16  source 0 payload byte count, sampled with s0_start_en
- s0_data  in  32  source 0 payload word
- s0_req  out  1  tx_req forwarded to source 0 while granted
- s0_done  out  1  tx_done forwarded to source 0
- s0_busy  out  1  source 0 request pending or granted
- s1_start_en, s1_byte_num, s1_data, s1_req, s1_done, s1_busy  same as s0_* for source 1
- udp_tx_start_en  out  1  start pulse to UDP module
- udp_tx_byte_num  out  16  byte count to UDP module
- udp_tx_data  out  32  payload word to UDP module
- udp_tx_req  in  1  UDP data request
- udp_tx_done  in  1  UDP packet done pulse
- arb_timeout  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: all outputs 0. State IDLE. Pending flags 0. Round-robin pointer = source 1, so source 0 wins the first tie.
- Request latch:
  - sN_start_en with sN_byte_num != 0 sets pendN and captures byte_numN.
  - byte_num == 0 is dropped: no grant, no flag.
  - start_en while pendN=1 or source N is granted is ignored.
- sN_busy = pendN | (grant==N and state != IDLE).
- State IDLE:
  - If any pending flag is set, pick a winner.
  - SRC0_STRICT=1: source 0 first.
  - Otherwise round-robin: the source not granted last wins a tie; a lone requester always wins.
  - Registered transition to START. Clear the winner's pend flag. Load udp_tx_byte_num from the winner's capture. Update the pointer.
- State START: udp_tx_start_en=1 for exactly one cycle. Next state BUSY.
- Latency: start_en to udp_tx_start_en is 2 cycles when IDLE.
- State BUSY:
  - udp_tx_data = data of the granted source (combinational mux).
  - sN_req = udp_tx_req for the granted source only; 0 for the other.
  - On udp_tx_done: sN_done=1 for one cycle for the granted source; go to GAP.
  - Timeout counter counts from the START cycle. At TIMEOUT_CYCLES without done: arb_timeout pulse, no sN_done, go to GAP.
  - udp_tx_done while IDLE/GAP/START is ignored.
- State GAP:
  - Counter runs GAP_CYCLES cycles, then IDLE.
  - GAP_CYCLES=0 goes straight to IDLE.
  - Requests arriving during GAP are latched normally.
- Between packets: udp_tx_byte_num holds its last value; udp_tx_data = 0 outside BUSY.
- Counters: 16-bit, saturating, cleared on state entry.
- rst mid-packet: immediate IDLE, pend flags cleared, no done pulses.

Optional Feature:
- Macro UDP_TX_ARB_STATS_EN.
- Defined: adds outputs s0_pkt_cnt[31:0], s1_pkt_cnt[31:0], drop_cnt[15:0], timeout_cnt[15:0].
  - pkt_cnt increments on each forwarded sN_done.
  - drop_cnt increments on each ignored or zero-length start_en.
  - All wrap, all reset to 0.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package udp_tx_arb_pkg holds:
  - state enum {IDLE, START, BUSY, GAP};
  - source-index typedef (1 bit);
  - constants SRC_IMG=0, SRC_CMD=1.
- One sub-module, udp_tx_arb_pick: combinational winner select (pend flags, pointer, SRC0_STRICT). The FSM and counters stay in the top module.

Test Plan:
1. Single request: s0_start_en with byte_num=1024 → udp_tx_start_en 2 cycles later, udp_tx_byte_num=1024, udp_tx_req mirrored on s0_req only, tx_done → s0_done pulse, then 16 gap cycles.
2. Simultaneous s0/s1 start_en, SRC0_STRICT=0 → order s0, s1, s0, s1 over four rounds; with SRC0_STRICT=1 and s0 re-requesting every gap → s1 starves and s0 is always granted.
3. Request during BUSY: s1_start_en byte_num=8 while s0 is granted → s1_busy=1 immediately, s1 granted exactly GAP_CYCLES+1 cycles after s0 tx_done.
4. Zero length and duplicates: s0 byte_num=0 → no grant, s0_busy stays 0; second s0_start_en while pending → a single packet only (drop_cnt=2 with stats).
5. Timeout: TIMEOUT_CYCLES=100, no tx_done → arb_timeout pulse at cycle 100 after start, no s0_done, pending s1 granted after the gap.
6. rst asserted mid-BUSY → next cycle all outputs 0, pending lost; a fresh request after release gets the 2-cycle latency.
